// File: rtl/analyzer_trig_ctrl.sv
// analyzer_trig_ctrl
// Trigger and sequencing controller for the logic-analyzer capture store.
// It evaluates a per-channel level/edge trigger condition on the probed
// inputs and supports force and timeout triggers. When a trigger fires, it
// issues a one-cycle trig pulse. It then follows the store's busy/done
// handshake to report capture status.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   digital_in       probed channels (synchronous to clk)
//   cfg_level_mask   channel enable for the level condition
//   cfg_level_val    required level per channel
//   cfg_edge_mask    channel enable for the edge condition
//   cfg_edge_rise    1 = rising edge, 0 = falling edge
//   cfg_or_mode      0 = AND of enabled terms, 1 = OR of enabled terms
//   cfg_timeout      forced trigger after this many armed cycles (0 = off)
//   arm              pulse: arm / re-arm; latches all cfg_* inputs
//   force_trig       pulse: trigger immediately while armed
//                    ("force" is a reserved word, hence the longer name)
//   abort            pulse: disarm (only honoured while armed)
//   store_busy       capture store busy
//   store_done       capture store done
//   trig             one-cycle trigger pulse to the store
//   armed            high while armed
//   capturing        high from the trigger until the store reports done
//   cap_done         high once the capture is complete
//   trig_cause       00 none, 01 condition, 10 force, 11 timeout
//   trig_delay       armed-cycle counter value at the moment of the fire
module analyzer_trig_ctrl #(
  parameter int DIGITAL_IN_NUM = 8,
  parameter int TIMEOUT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DIGITAL_IN_NUM-1:0] digital_in,
  input  logic [DIGITAL_IN_NUM-1:0] cfg_level_mask,
  input  logic [DIGITAL_IN_NUM-1:0] cfg_level_val,
  input  logic [DIGITAL_IN_NUM-1:0] cfg_edge_mask,
  input  logic [DIGITAL_IN_NUM-1:0] cfg_edge_rise,
  input  logic                      cfg_or_mode,
  input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout,
  input  logic                      arm,
  input  logic                      force_trig,
  input  logic                      abort,
  input  logic                      store_busy,
  input  logic                      store_done,
  output logic                      trig,
  output logic                      armed,
  output logic                      capturing,
  output logic                      cap_done,
  output logic [1:0]                trig_cause,
  output logic [TIMEOUT_WIDTH-1:0]  trig_delay
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED      = 3'd1,
    ST_FIRE       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_CAPTURE    = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ZERO = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX  = {TIMEOUT_WIDTH{1'b1}};

  state_t                      state_r, next_state_s;
  logic [DIGITAL_IN_NUM-1:0]   d_q_r, d_qq_r;
  logic [DIGITAL_IN_NUM-1:0]   lvl_mask_r, lvl_val_r, edge_mask_r, edge_rise_r;
  logic                        or_mode_r;
  logic [TIMEOUT_WIDTH-1:0]    timeout_r, cnt_r;
  logic [DIGITAL_IN_NUM-1:0]   lvl_term_s, edge_term_s;
  logic                        and_hit_s, or_hit_s, hit_s, tmo_s, fire_s;
  logic                        arm_acc_s, fire_entry_s;
  logic [1:0]                  cause_s;
  logic                        trig_nxt_s, armed_nxt_s, capt_nxt_s, done_nxt_s;
  logic                        trig_r, armed_r, capt_r, done_r;
  logic [1:0]                  cause_r;
  logic [TIMEOUT_WIDTH-1:0]    delay_r;

  // Trigger condition from the two-stage input history and the latched config.
  always_comb begin
    lvl_term_s  = ~(d_q_r ^ lvl_val_r);
    edge_term_s = (edge_rise_r & d_q_r & ~d_qq_r) | (~edge_rise_r & ~d_q_r & d_qq_r);
    // Disabled channels are neutral: 1 for AND, 0 for OR.
    and_hit_s   = (&(lvl_term_s | ~lvl_mask_r)) & (&(edge_term_s | ~edge_mask_r));
    or_hit_s    = (|(lvl_term_s & lvl_mask_r)) | (|(edge_term_s & edge_mask_r));
    hit_s       = or_mode_r ? or_hit_s : and_hit_s;
    tmo_s       = (timeout_r != CNT_ZERO) && (cnt_r == (timeout_r - CNT_ONE));
    fire_s      = hit_s | force_trig | tmo_s;
    if (hit_s) begin
      cause_s = 2'b01;
    end else if (force_trig) begin
      cause_s = 2'b10;
    end else if (tmo_s) begin
      cause_s = 2'b11;
    end else begin
      cause_s = 2'b00;
    end
  end

  // An arm is accepted in IDLE and DONE, and in ARMED unless abort is also present.
  always_comb begin
    case (state_r)
      ST_IDLE, ST_DONE: arm_acc_s = arm;
      ST_ARMED:         arm_acc_s = arm & ~abort;
      default:          arm_acc_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. In ARMED the order is abort, then re-arm, then fire.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arm) next_state_s = ST_ARMED;
        else     next_state_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (abort)       next_state_s = ST_IDLE;
        else if (arm)    next_state_s = ST_ARMED;
        else if (fire_s) next_state_s = ST_FIRE;
        else             next_state_s = ST_ARMED;
      end
      ST_FIRE:       next_state_s = ST_WAIT_START;
      ST_WAIT_START: begin
        if (store_busy) next_state_s = ST_CAPTURE;
        else            next_state_s = ST_WAIT_START;
      end
      ST_CAPTURE: begin
        if (store_done) next_state_s = ST_DONE;
        else            next_state_s = ST_CAPTURE;
      end
      ST_DONE: begin
        if (arm) next_state_s = ST_ARMED;
        else     next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode of the next state; registered below so it lines up with the state.
  always_comb begin
    trig_nxt_s  = 1'b0;
    armed_nxt_s = 1'b0;
    capt_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (next_state_s)
      ST_ARMED:      armed_nxt_s = 1'b1;
      ST_FIRE: begin
        trig_nxt_s = 1'b1;
        capt_nxt_s = 1'b1;
      end
      ST_WAIT_START: capt_nxt_s = 1'b1;
      ST_CAPTURE:    capt_nxt_s = 1'b1;
      ST_DONE:       done_nxt_s = 1'b1;
      default: begin
        trig_nxt_s  = 1'b0;
        armed_nxt_s = 1'b0;
        capt_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  assign fire_entry_s = (state_r == ST_ARMED) && (next_state_s == ST_FIRE);

  // Status output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig_r  <= 1'b0;
      armed_r <= 1'b0;
      capt_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      trig_r  <= trig_nxt_s;
      armed_r <= armed_nxt_s;
      capt_r  <= capt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Input history; runs in every state so an edge at the arming edge is seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_q_r  <= {DIGITAL_IN_NUM{1'b0}};
      d_qq_r <= {DIGITAL_IN_NUM{1'b0}};
    end else begin
      d_q_r  <= digital_in;
      d_qq_r <= d_q_r;
    end
  end

  // Configuration snapshot taken on every accepted arm.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl_mask_r  <= {DIGITAL_IN_NUM{1'b0}};
      lvl_val_r   <= {DIGITAL_IN_NUM{1'b0}};
      edge_mask_r <= {DIGITAL_IN_NUM{1'b0}};
      edge_rise_r <= {DIGITAL_IN_NUM{1'b0}};
      or_mode_r   <= 1'b0;
      timeout_r   <= CNT_ZERO;
    end else if (arm_acc_s) begin
      lvl_mask_r  <= cfg_level_mask;
      lvl_val_r   <= cfg_level_val;
      edge_mask_r <= cfg_edge_mask;
      edge_rise_r <= cfg_edge_rise;
      or_mode_r   <= cfg_or_mode;
      timeout_r   <= cfg_timeout;
    end else begin
      lvl_mask_r  <= lvl_mask_r;
      lvl_val_r   <= lvl_val_r;
      edge_mask_r <= edge_mask_r;
      edge_rise_r <= edge_rise_r;
      or_mode_r   <= or_mode_r;
      timeout_r   <= timeout_r;
    end
  end

  // Saturating armed-cycle counter, cleared on every entry to ARMED.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= CNT_ZERO;
    end else if (arm_acc_s) begin
      cnt_r <= CNT_ZERO;
    end else if ((state_r == ST_ARMED) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Trigger cause and delay capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cause_r <= 2'b00;
      delay_r <= CNT_ZERO;
    end else if (arm_acc_s) begin
      cause_r <= 2'b00;
      delay_r <= delay_r;
    end else if (fire_entry_s) begin
      cause_r <= cause_s;
      delay_r <= cnt_r;
    end else begin
      cause_r <= cause_r;
      delay_r <= delay_r;
    end
  end

  assign trig       = trig_r;
  assign armed      = armed_r;
  assign capturing  = capt_r;
  assign cap_done   = done_r;
  assign trig_cause = cause_r;
  assign trig_delay = delay_r;

endmodule

// File: tb/tb_analyzer_trig_ctrl.sv
module tb_analyzer_trig_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  digital_in = 8'h00;
  logic [7:0]  cfg_level_mask = 8'h00, cfg_level_val = 8'h00;
  logic [7:0]  cfg_edge_mask = 8'h00, cfg_edge_rise = 8'h00;
  logic        cfg_or_mode = 1'b0;
  logic [31:0] cfg_timeout = 32'd0;
  logic        arm = 1'b0, force_trig = 1'b0, abort = 1'b0;
  logic        store_busy = 1'b0, store_done = 1'b0;
  logic        trig, armed, capturing, cap_done;
  logic [1:0]  trig_cause;
  logic [31:0] trig_delay;

  int checks = 0;
  int failures = 0;

  analyzer_trig_ctrl #(.DIGITAL_IN_NUM(8), .TIMEOUT_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .digital_in(digital_in),
    .cfg_level_mask(cfg_level_mask), .cfg_level_val(cfg_level_val),
    .cfg_edge_mask(cfg_edge_mask), .cfg_edge_rise(cfg_edge_rise),
    .cfg_or_mode(cfg_or_mode), .cfg_timeout(cfg_timeout),
    .arm(arm), .force_trig(force_trig), .abort(abort),
    .store_busy(store_busy), .store_done(store_done),
    .trig(trig), .armed(armed), .capturing(capturing), .cap_done(cap_done),
    .trig_cause(trig_cause), .trig_delay(trig_delay)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm, frc, abrt, busy, done;
    logic [7:0]  din, lm, lv, em, er;
    logic        orm;
    logic [31:0] to;
    logic [3:0]  st;     // {trig, armed, capturing, cap_done}
    logic [1:0]  cause;
    logic [31:0] dly;
  } vec_t;

  vec_t tbl[$];
  logic [7:0]  cur_lm, cur_lv, cur_em, cur_er;
  logic        cur_orm;
  logic [31:0] cur_to;

  task automatic set_cfg(input logic [7:0] lm, lv, em, er, input logic orm, input logic [31:0] to);
    cur_lm = lm; cur_lv = lv; cur_em = em; cur_er = er; cur_orm = orm; cur_to = to;
  endtask

  task automatic add(input logic a, f, ab, b, d, input logic [7:0] din,
                     input logic [3:0] st, input logic [1:0] c, input logic [31:0] dl);
    vec_t v;
    v.arm = a; v.frc = f; v.abrt = ab; v.busy = b; v.done = d; v.din = din;
    v.lm = cur_lm; v.lv = cur_lv; v.em = cur_em; v.er = cur_er;
    v.orm = cur_orm; v.to = cur_to;
    v.st = st; v.cause = c; v.dly = dl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [3:0] st_e,
                     input logic [1:0] c_e, input logic [31:0] d_e);
    logic [3:0] st_g;
    st_g = {trig, armed, capturing, cap_done};
    checks++;
    if (st_g !== st_e || trig_cause !== c_e || trig_delay !== d_e) begin
      failures++;
      $display("FAIL %s[%0d]: got trig/armed/capt/done=%b cause=%b delay=%0d, expected %b cause=%b delay=%0d",
               nm, idx, st_g, trig_cause, trig_delay, st_e, c_e, d_e);
    end
  endtask

  task automatic clear_pulses();
    arm = 1'b0; force_trig = 1'b0; abort = 1'b0; store_busy = 1'b0; store_done = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1 chk("reset", 0, 4'b0000, 2'b00, 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1 chk("idle_after_reset", 0, 4'b0000, 2'b00, 32'd0);

    //            arm frc abt bsy don din    st       cause  dly
    // Rising edge on channel 0, AND mode.
    set_cfg(8'h00, 8'h00, 8'h01, 8'h01, 1'b0, 32'd0);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd0);   // 0 arm
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b0100, 2'b00, 32'd0);   // 0->1 sampled here
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b1010, 2'b01, 32'd2);   // FIRE next edge
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b0010, 2'b01, 32'd2);   // WAIT_START
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h01, 4'b0010, 2'b01, 32'd2);   // CAPTURE
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h01, 4'b0010, 2'b01, 32'd2);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h01, 4'b0001, 2'b01, 32'd2);   // DONE
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b0001, 2'b01, 32'd2);
    // Level pattern 0xA? in AND mode; abort/arm/force ignored in CAPTURE.
    set_cfg(8'hF0, 8'hA0, 8'h00, 8'h00, 1'b0, 32'd0);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h50, 4'b0100, 2'b00, 32'd2);   // 9 re-arm from DONE
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'hA3, 4'b0100, 2'b00, 32'd2);   // 0x50 evaluated: no hit
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'hA3, 4'b1010, 2'b01, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'hA3, 4'b0010, 2'b01, 32'd1);
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'hA3, 4'b0010, 2'b01, 32'd1);
    add(1'b0,1'b0,1'b1,1'b1,1'b0, 8'hA3, 4'b0010, 2'b01, 32'd1);   // abort ignored
    add(1'b1,1'b1,1'b0,1'b1,1'b0, 8'hA3, 4'b0010, 2'b01, 32'd1);   // arm/force ignored
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 8'hA3, 4'b0001, 2'b01, 32'd1);
    // Timeout 5, OR mode with no terms.
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'd5);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd1);   // 17
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b1010, 2'b11, 32'd4);   // 6th cycle after arm
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0010, 2'b11, 32'd4);
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 4'b0010, 2'b11, 32'd4);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h00, 4'b0001, 2'b11, 32'd4);
    // Force together with condition -> condition; then force alone.
    set_cfg(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 32'd0);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd4);   // 26
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b0100, 2'b00, 32'd4);
    add(1'b0,1'b1,1'b0,1'b0,1'b0, 8'h01, 4'b1010, 2'b01, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0010, 2'b01, 32'd1);
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 4'b0010, 2'b01, 32'd1);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h00, 4'b0001, 2'b01, 32'd1);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd1);   // 32
    add(1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 4'b1010, 2'b10, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0010, 2'b10, 32'd0);
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00, 4'b0010, 2'b10, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b1, 8'h00, 4'b0001, 2'b10, 32'd0);
    add(1'b0,1'b1,1'b1,1'b0,1'b0, 8'h00, 4'b0001, 2'b10, 32'd0);   // force/abort ignored in DONE
    // Arm + abort while ARMED -> IDLE; force/abort ignored in IDLE.
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 32'd0);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd0);   // 38
    add(1'b1,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 2'b00, 32'd0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 4'b0000, 2'b00, 32'd0);
    add(1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 2'b00, 32'd0);
    // Reconfigure while ARMED: latched config (level 1) still governs.
    set_cfg(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 32'd0);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd0);   // 42
    set_cfg(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0100, 2'b00, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b0100, 2'b00, 32'd0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b1010, 2'b01, 32'd3);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 8'h01, 4'b0010, 2'b01, 32'd3);
    add(1'b0,1'b0,1'b0,1'b1,1'b0, 8'h01, 4'b0010, 2'b01, 32'd3);   // 48 CAPTURE

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      arm = tbl[i].arm; force_trig = tbl[i].frc; abort = tbl[i].abrt;
      store_busy = tbl[i].busy; store_done = tbl[i].done; digital_in = tbl[i].din;
      cfg_level_mask = tbl[i].lm; cfg_level_val = tbl[i].lv;
      cfg_edge_mask = tbl[i].em; cfg_edge_rise = tbl[i].er;
      cfg_or_mode = tbl[i].orm; cfg_timeout = tbl[i].to;
      @(posedge clk); #1 chk("vec", i, tbl[i].st, tbl[i].cause, tbl[i].dly);
    end

    // Asynchronous reset mid-capture clears everything without a clock edge.
    @(negedge clk); clear_pulses(); store_busy = 1'b1;
    #2 rstn = 1'b0;
    #1 chk("async_reset", 0, 4'b0000, 2'b00, 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1 chk("idle_after_async_reset", 0, 4'b0000, 2'b00, 32'd0);

    // Edge whose first post-edge sample lands on the arming edge fires next cycle.
    @(negedge clk); store_busy = 1'b0; digital_in = 8'h00;
    @(negedge clk);
    cfg_level_mask = 8'h00; cfg_edge_mask = 8'h01; cfg_edge_rise = 8'h01;
    cfg_or_mode = 1'b0; cfg_timeout = 32'd0;
    arm = 1'b1; digital_in = 8'h01;
    @(posedge clk); #1 chk("edge_at_arm_armed", 0, 4'b0100, 2'b00, 32'd0);
    @(negedge clk) arm = 1'b0;
    @(posedge clk); #1 chk("edge_at_arm_fire", 0, 4'b1010, 2'b01, 32'd0);
    @(posedge clk); #1 chk("edge_at_arm_wait", 0, 4'b0010, 2'b01, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
